alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 64-bit ALU between two requesters: port 0 is the execute stage and port 1 is the address-generation/branch-target unit.
- Round-robin grant; each request carries a complete ALU operation.
- The ALU result is captured in a single output register, and the owning requester pops it with a valid/ready handshake.
- Steady-state throughput is 1 operation/cycle when the consumer is always ready; latency is 1 cycle from grant to response.

Parameters:
XLEN, 64, datapath width of operands and result; must match the ALU.
OP_W, 5, width of the ALU operation field.
SRC_W, 3, width of the ALU src1/src2 select fields.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  2  bit i: requester i presents an operation.
req_ready  out  2  bit i: requester i's operation is granted this cycle (one-hot or zero).
req_op  in  2*OP_W  per-requester ALU operation code, passed to the ALU unchanged.
req_sub_sra  in  2  per-requester subtract/arithmetic-shift select.
req_src1  in  2*SRC_W  per-requester src1 select.
req_src2  in  2*SRC_W  per-requester src2 select.
req_pc  in  2*XLEN  per-requester PC operand.
req_rs1  in  2*XLEN  per-requester rs1 operand.
req_rs2  in  2*XLEN  per-requester rs2 operand.
req_imm  in  2*XLEN  per-requester immediate operand.
resp_valid  out  2  bit i: result for requester i is held in the output register.
resp_ready  in  2  bit i: requester i accepts its result.
resp_result  out  XLEN  registered ALU result, shared by both requesters; qualify with resp_valid.
resp_non_zero  out  1  registered ALU non-zero flag.
alu_op, alu_sub_sra, alu_src1, alu_src2, alu_pc, alu_rs1, alu_rs2, alu_imm  out  OP_W/1/SRC_W/SRC_W/XLEN x4  operation driven to the ALU.
alu_result  in  XLEN  ALU result.
alu_non_zero  in  1  ALU non-zero flag.

Behaviour:
- States: IDLE (output register empty) and HOLD (output register full, owner tag = 0 or 1).
- can_issue = IDLE, or HOLD with resp_valid[owner] && resp_ready[owner] in the same cycle (pop plus back-to-back issue).
- Grant:
  - When can_issue and any req_valid is set, grant exactly one requester.
  - Both valid: grant the requester named by priority pointer prio.
  - One valid: grant that requester regardless of prio.
  - After any grant, prio becomes the non-granted index.
- req_ready[i] = grant[i]; it is combinational and may depend on resp_ready.
- ALU drive:
  - On grant, the alu_* outputs carry the granted requester's fields.
  - With no grant, all alu_* outputs are 0 and no register updates from the ALU.
- On a grant edge: result register <= alu_result, nz register <= alu_non_zero, owner <= granted index; next state HOLD.
- HOLD, owner pops, no new grant: next state IDLE; the result register keeps its value.
- HOLD, owner not ready: state, result, owner and prio are all held; req_ready = 0 for both requesters. No timeout.
- resp_valid[i] = (state == HOLD) && (owner == i); never both bits set.
- resp_ready of the non-owner is ignored.
- Fairness: under continuous dual requests with both consumers ready, grants strictly alternate 0,1,0,1,...
- Reset (asynchronous, any state, including mid-HOLD): state = IDLE, prio = 0, owner = 0, result = 0, nz = 0, resp_valid = 0. req_ready = 0 until reset is released. A pending result is discarded.
- No arithmetic is performed in this block; operand widths are passed through unchanged.

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE, HOLD};
  - struct alu_req_t {op, sub_sra, src1, src2, pc, rs1, rs2, imm};
  - constant NUM_REQ = 2.
- Sub-module rr_arb2: inputs req[1:0], en, prio; outputs one-hot grant and next_prio; purely combinational.
- Top level holds the state register, output register, and ALU mux.

Test Plan:
- Reset mid-HOLD: req0 ADD (op 0, sub 0, src1/src2 = REG 0) rs1=5, rs2=7 granted, resp_ready low; assert reset -> resp_valid=00 and resp_result=0 immediately; after release, IDLE and prio=0.
- Single op: req0 ADD rs1=5, rs2=7, resp_ready=1 -> req_ready=01 in the issue cycle; next cycle resp_valid=01, resp_result=12, resp_non_zero=1.
- Subtract zero: req1 sub_sra=1, rs1=3, rs2=3 -> resp_valid=10, resp_result=0, resp_non_zero=0.
- Contention: both valid for 6 cycles, both resp_ready=1 -> grants 0,1,0,1,0,1; one response per cycle; each result tagged to the correct owner.
- Backpressure: owner 0 holds resp_ready=0 for 4 cycles while req1 is valid -> req_ready=00 and resp_result stable throughout; pop cycle grants req1; next cycle resp_valid=10.
- Idle drive: no req_valid -> alu_* outputs all 0, req_ready=00, state stays IDLE.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the two-requester ALU arbiter.
//   state_t   : output-register occupancy (IDLE = empty, HOLD = full)
//   alu_req_t : one complete ALU operation as presented by a requester
//   NUM_REQ   : number of requesters sharing the ALU
//   DEF_*     : default datapath/field widths, used as parameter defaults
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_OP_W  = 5;
  localparam int DEF_SRC_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_OP_W-1:0]  op;
    logic                 sub_sra;
    logic [DEF_SRC_W-1:0] src1;
    logic [DEF_SRC_W-1:0] src2;
    logic [DEF_XLEN-1:0]  pc;
    logic [DEF_XLEN-1:0]  rs1;
    logic [DEF_XLEN-1:0]  rs2;
    logic [DEF_XLEN-1:0]  imm;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bus between the two requesters and the ALU arbiter.
// Per-requester fields are packed side by side, requester 1 in the upper half.
//
// Handshake semantics (both channels, per requester i):
//   request : an operation transfers on a rising edge where req_valid[i] and
//             req_ready[i] are both 1. req_ready is combinational and is
//             one-hot or zero; it may depend on resp_ready in the same cycle.
//   response: the held result transfers on a rising edge where resp_valid[i]
//             and resp_ready[i] are both 1. At most one resp_valid bit is set;
//             resp_ready of the other requester is ignored. resp_result and
//             resp_non_zero are shared and only meaningful with resp_valid.
//
// Modports:
//   master : requester side (drives req_* fields and resp_ready)
//   slave  : arbiter side  (drives req_ready and resp_*)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int OP_W  = 5,
  parameter int SRC_W = 3
) ();

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*OP_W-1:0]  req_op;
  logic [1:0]         req_sub_sra;
  logic [2*SRC_W-1:0] req_src1;
  logic [2*SRC_W-1:0] req_src2;
  logic [2*XLEN-1:0]  req_pc;
  logic [2*XLEN-1:0]  req_rs1;
  logic [2*XLEN-1:0]  req_rs2;
  logic [2*XLEN-1:0]  req_imm;

  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [XLEN-1:0]    resp_result;
  logic               resp_non_zero;

  modport master (
    output req_valid, req_op, req_sub_sra, req_src1, req_src2,
           req_pc, req_rs1, req_rs2, req_imm, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_non_zero
  );

  modport slave (
    input  req_valid, req_op, req_sub_sra, req_src1, req_src2,
           req_pc, req_rs1, req_rs2, req_imm, resp_ready,
    output req_ready, resp_valid, resp_result, resp_non_zero
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic, purely combinational.
//   req[1:0]  : request bits
//   en        : grants allowed this cycle
//   prio      : index that wins when both request
//   grant[1:0]: one-hot grant, or zero
//   next_prio : priority to use after this cycle (the non-granted index after
//               a grant, otherwise unchanged)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       next_prio
);

  always_comb begin
    grant     = 2'b00;
    next_prio = prio;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    // The loser (or the idle side) gets priority next time.
    if (grant != 2'b00) begin
      next_prio = ~grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between the execute stage (requester
// 0) and the address-generation/branch-target unit (requester 1). A granted
// operation is steered onto the alu_* outputs, the ALU answer is captured in a
// single output register on the same edge, and the owning requester pops it.
// A pop and a new grant may share a cycle, giving one op per cycle when the
// consumer is always ready.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   bus (slave)         : request/response bus, see alu_arbiter_if
//   alu_op .. alu_imm   : operation driven to the ALU (all zero without grant)
//   alu_result          : ALU result
//   alu_non_zero        : ALU non-zero flag
//   state_dbg           : output-register state (IDLE/HOLD)
//   prio_dbg            : round-robin priority pointer
//   owner_dbg           : owner tag of the held result
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int OP_W  = DEF_OP_W,
  parameter int SRC_W = DEF_SRC_W
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_sub_sra,
  output logic [SRC_W-1:0] alu_src1,
  output logic [SRC_W-1:0] alu_src2,
  output logic [XLEN-1:0]  alu_pc,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  output logic [XLEN-1:0]  alu_imm,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_non_zero,
  output state_t           state_dbg,
  output logic             prio_dbg,
  output logic             owner_dbg
);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              nz_q, nz_d;

  logic              pop;
  logic              can_issue;
  logic [1:0]        grant;
  logic              grant_any;
  logic              gidx;
  logic              next_prio;

  // Owner consumes its result this cycle; only the owner's ready matters.
  assign pop       = (state_q == HOLD) && bus.resp_ready[owner_q];
  assign can_issue = (state_q == IDLE) || pop;

  // Reset gates the grant so req_ready stays low while reset is asserted,
  // even though the state already reads IDLE.
  rr_arb2 u_rr_arb2 (
    .req       (bus.req_valid),
    .en        (can_issue && !reset),
    .prio      (prio_q),
    .grant     (grant),
    .next_prio (next_prio)
  );

  assign grant_any     = |grant;
  assign gidx          = grant[1];
  assign bus.req_ready = grant;

  // ALU operand mux: granted requester's fields, or all zero.
  always_comb begin
    alu_op      = '0;
    alu_sub_sra = 1'b0;
    alu_src1    = '0;
    alu_src2    = '0;
    alu_pc      = '0;
    alu_rs1     = '0;
    alu_rs2     = '0;
    alu_imm     = '0;
    if (grant_any) begin
      if (gidx) begin
        alu_op      = bus.req_op[2*OP_W-1:OP_W];
        alu_sub_sra = bus.req_sub_sra[1];
        alu_src1    = bus.req_src1[2*SRC_W-1:SRC_W];
        alu_src2    = bus.req_src2[2*SRC_W-1:SRC_W];
        alu_pc      = bus.req_pc[2*XLEN-1:XLEN];
        alu_rs1     = bus.req_rs1[2*XLEN-1:XLEN];
        alu_rs2     = bus.req_rs2[2*XLEN-1:XLEN];
        alu_imm     = bus.req_imm[2*XLEN-1:XLEN];
      end else begin
        alu_op      = bus.req_op[OP_W-1:0];
        alu_sub_sra = bus.req_sub_sra[0];
        alu_src1    = bus.req_src1[SRC_W-1:0];
        alu_src2    = bus.req_src2[SRC_W-1:0];
        alu_pc      = bus.req_pc[XLEN-1:0];
        alu_rs1     = bus.req_rs1[XLEN-1:0];
        alu_rs2     = bus.req_rs2[XLEN-1:0];
        alu_imm     = bus.req_imm[XLEN-1:0];
      end
    end
  end

  // Next-state logic. A grant always lands in HOLD (covers pop+issue);
  // a pop with no new grant empties the register but leaves its contents.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    result_d = result_q;
    nz_d     = nz_q;
    if (grant_any) begin
      state_d  = HOLD;
      owner_d  = gidx;
      prio_d   = next_prio;
      result_d = alu_result;
      nz_d     = alu_non_zero;
    end else if (pop) begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      nz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      nz_q     <= nz_d;
    end
  end

  assign bus.resp_valid    = (state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_result   = result_q;
  assign bus.resp_non_zero = nz_q;

  assign state_dbg = state_q;
  assign prio_dbg  = prio_q;
  assign owner_dbg = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed scenarios followed by a randomized run for alu_arbiter. A small
// behavioural ALU stands in for the real one; the reference model tracks at
// most one pending response in a queue plus a round-robin pointer.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int XLEN  = DEF_XLEN;
  localparam int OP_W  = DEF_OP_W;
  localparam int SRC_W = DEF_SRC_W;
  localparam int W     = XLEN + 2;   // {owner, nz, result}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  alu_arbiter_if #(.XLEN(XLEN), .OP_W(OP_W), .SRC_W(SRC_W)) bus ();

  logic [OP_W-1:0]  alu_op;
  logic             alu_sub_sra;
  logic [SRC_W-1:0] alu_src1;
  logic [SRC_W-1:0] alu_src2;
  logic [XLEN-1:0]  alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [XLEN-1:0]  alu_result;
  logic             alu_non_zero;
  state_t           state_dbg;
  logic             prio_dbg;
  logic             owner_dbg;

  alu_arbiter #(.XLEN(XLEN), .OP_W(OP_W), .SRC_W(SRC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_op       (alu_op),
    .alu_sub_sra  (alu_sub_sra),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_pc       (alu_pc),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_imm      (alu_imm),
    .alu_result   (alu_result),
    .alu_non_zero (alu_non_zero),
    .state_dbg    (state_dbg),
    .prio_dbg     (prio_dbg),
    .owner_dbg    (owner_dbg)
  );

  // Requester-side stimulus variables
  alu_req_t   r [2];
  logic [1:0] valid_v;
  logic [1:0] rready_v;

  assign bus.req_valid   = valid_v;
  assign bus.resp_ready  = rready_v;
  assign bus.req_op      = {r[1].op, r[0].op};
  assign bus.req_sub_sra = {r[1].sub_sra, r[0].sub_sra};
  assign bus.req_src1    = {r[1].src1, r[0].src1};
  assign bus.req_src2    = {r[1].src2, r[0].src2};
  assign bus.req_pc      = {r[1].pc, r[0].pc};
  assign bus.req_rs1     = {r[1].rs1, r[0].rs1};
  assign bus.req_rs2     = {r[1].rs2, r[0].rs2};
  assign bus.req_imm     = {r[1].imm, r[0].imm};

  // ---------------- behavioural ALU ----------------
  // src select: 0 = register, 1 = pc/imm, other = zero. Returns {nz, result}.
  function automatic logic [XLEN:0] alu_ref(alu_req_t q);
    logic [XLEN-1:0] a, b, y;
    a = (q.src1 == 0) ? q.rs1 : (q.src1 == 1) ? q.pc  : '0;
    b = (q.src2 == 0) ? q.rs2 : (q.src2 == 1) ? q.imm : '0;
    case (q.op)
      5'd0:    y = q.sub_sra ? a - b : a + b;
      5'd1:    y = a ^ b;
      5'd2:    y = a | b;
      5'd3:    y = a & b;
      5'd4:    y = a << b[5:0];
      5'd5:    y = q.sub_sra ? XLEN'($signed(a) >>> b[5:0]) : a >> b[5:0];
      5'd6:    y = XLEN'($signed(a) < $signed(b));
      default: y = a + b;
    endcase
    return {(y != '0), y};
  endfunction

  alu_req_t drv;
  always_comb begin
    drv = '{op: alu_op, sub_sra: alu_sub_sra, src1: alu_src1, src2: alu_src2,
            pc: alu_pc, rs1: alu_rs1, rs2: alu_rs2, imm: alu_imm};
    {alu_non_zero, alu_result} = alu_ref(drv);
  end

  // ---------------- scoreboard / model ----------------
  logic [W-1:0]    exp_q[$];
  logic            m_prio;
  logic [XLEN-1:0] m_last_res;
  logic            m_last_nz;
  logic [1:0]      obs_grant;
  int              pass_cnt  = 0;
  int              total_cnt = 0;
  int              fail_cnt  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prio     = 1'b0;
    m_last_res = '0;
    m_last_nz  = 1'b0;
  endtask

  function automatic alu_req_t rand_req();
    alu_req_t q;
    q.op      = OP_W'($urandom_range(0, 7));
    q.sub_sra = 1'($urandom_range(0, 1));
    q.src1    = SRC_W'($urandom_range(0, 2));
    q.src2    = SRC_W'($urandom_range(0, 2));
    q.pc      = {$urandom, $urandom};
    q.rs1     = {$urandom, $urandom};
    q.rs2     = ($urandom_range(0, 3) == 0) ? q.rs1 : {$urandom, $urandom};
    q.imm     = XLEN'($urandom_range(0, 70));
    return q;
  endfunction

  // One clock: check at the falling edge against the model, commit the model,
  // then return 1 time unit after the rising edge so the caller can drive.
  task automatic cycle();
    logic         pending;
    logic         own;
    logic         can;
    logic [1:0]   e_grant;
    logic         g;
    logic [XLEN:0] res;
    @(negedge clk);
    pending = (exp_q.size() != 0);
    own     = pending ? exp_q[0][W-1] : 1'b0;
    can     = !pending || rready_v[own];
    e_grant = 2'b00;
    if (can) e_grant = (valid_v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : valid_v;
    g = e_grant[1];
    obs_grant = bus.req_ready;

    check("req_ready", 128'(bus.req_ready), 128'(e_grant));
    check("resp_valid", 128'(bus.resp_valid),
          128'(pending ? (own ? 2'b10 : 2'b01) : 2'b00));
    check("resp_result", 128'(bus.resp_result),
          128'(pending ? exp_q[0][XLEN-1:0] : m_last_res));
    check("resp_non_zero", 128'(bus.resp_non_zero),
          128'(pending ? exp_q[0][XLEN] : m_last_nz));
    check("state", 128'(state_dbg), 128'(pending ? HOLD : IDLE));
    check("prio", 128'(prio_dbg), 128'(m_prio));
    if (e_grant != 2'b00) begin
      check("alu_ctl", 128'({alu_op, alu_sub_sra, alu_src1, alu_src2}),
            128'({r[g].op, r[g].sub_sra, r[g].src1, r[g].src2}));
      check("alu_ops", 128'({alu_rs1, alu_rs2}), 128'({r[g].rs1, r[g].rs2}));
      check("alu_pc_imm", 128'({alu_pc, alu_imm}), 128'({r[g].pc, r[g].imm}));
    end else begin
      check("alu_idle_ctl", 128'({alu_op, alu_sub_sra, alu_src1, alu_src2}), 128'(0));
      check("alu_idle_data", 128'({alu_pc, alu_rs1, alu_rs2, alu_imm} != '0), 128'(0));
    end

    if (pending && rready_v[own]) void'(exp_q.pop_front());
    if (e_grant != 2'b00) begin
      res = alu_ref(r[g]);
      exp_q.push_back({g, res});
      m_last_res = res[XLEN-1:0];
      m_last_nz  = res[XLEN];
      m_prio     = ~g;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic alu_req_t add_req(input logic sub, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    alu_req_t q;
    q = '0;
    q.sub_sra = sub;
    q.rs1     = a;
    q.rs2     = b;
    return q;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] exp_g;
    logic [XLEN-1:0] held;
    reset    = 1'b1;
    valid_v  = 2'b00;
    rready_v = 2'b00;
    r[0]     = '0;
    r[1]     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle drive: nothing requested
    repeat (3) cycle();

    // Reset mid-HOLD
    r[0]     = add_req(1'b0, 64'd5, 64'd7);
    valid_v  = 2'b01;
    rready_v = 2'b00;
    cycle();
    valid_v  = 2'b00;
    cycle();
    valid_v  = 2'b01;
    #2 reset = 1'b1;
    #1;
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_result", 128'(bus.resp_result), 128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    model_reset();
    valid_v = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state", 128'(state_dbg), 128'(IDLE));
    check("rst_prio", 128'(prio_dbg), 128'(0));

    // Single op: 5 + 7
    r[0]     = add_req(1'b0, 64'd5, 64'd7);
    valid_v  = 2'b01;
    rready_v = 2'b11;
    cycle();
    valid_v  = 2'b00;
    check("single_valid", 128'(bus.resp_valid), 128'(2'b01));
    check("single_result", 128'(bus.resp_result), 128'(12));
    check("single_nz", 128'(bus.resp_non_zero), 128'(1));
    cycle();

    // Subtract to zero on requester 1
    r[1]    = add_req(1'b1, 64'd3, 64'd3);
    valid_v = 2'b10;
    cycle();
    valid_v = 2'b00;
    check("subz_valid", 128'(bus.resp_valid), 128'(2'b10));
    check("subz_result", 128'(bus.resp_result), 128'(0));
    check("subz_nz", 128'(bus.resp_non_zero), 128'(0));
    cycle();

    // Contention: strict alternation starting from the current pointer
    exp_g   = m_prio ? 2'b10 : 2'b01;
    valid_v = 2'b11;
    for (int k = 0; k < 6; k++) begin
      r[0] = rand_req();
      r[1] = rand_req();
      cycle();
      check("contention_grant", 128'(obs_grant), 128'(exp_g));
      exp_g = ~exp_g;
    end
    valid_v = 2'b00;
    cycle();

    // Backpressure: owner 0 stalls while requester 1 waits
    r[0]     = rand_req();
    valid_v  = 2'b01;
    rready_v = 2'b11;
    cycle();
    r[1]     = rand_req();
    valid_v  = 2'b10;
    rready_v = 2'b00;
    held     = m_last_res;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("bp_stable", 128'(bus.resp_result), 128'(held));
    end
    rready_v = 2'b01;
    cycle();
    valid_v  = 2'b00;
    rready_v = 2'b11;
    check("bp_owner1", 128'(bus.resp_valid), 128'(2'b10));
    cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) r[0] = rand_req();
      if ($urandom_range(0, 2) == 0) r[1] = rand_req();
      valid_v  = 2'($urandom_range(0, 3));
      rready_v = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
